// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and FSM state type for the fetch stage.
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hbfc0_0000;

    localparam logic [1:0] EXC_NONE = 2'b00;
    localparam logic [1:0] EXC_ADEL = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer with flush; head is read combinationally.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full buffer is only taken when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Next-state for storage, pointers and occupancy; flush discards everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // State registers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, single-outstanding group requests, decode-side queue,
// branch/exception redirect and misaligned-fetch flagging.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is shown on
// id_* in the same cycle and skips the queue if decode takes it immediately.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          ISSUE_W  = 2,
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    exc_valid,
    input  logic [31:0]             exc_pc,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_ready,
    input  logic                    imem_rvalid,
    input  logic [32*ISSUE_W-1:0]   imem_rdata,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [32*ISSUE_W-1:0]   id_inst,
    output logic [31:0]             id_pc,
    output logic [1:0]              id_exc,
    output logic [31:0]             pc
);

    typedef struct packed {
        logic [32*ISSUE_W-1:0] inst;
        logic [31:0]           pc;
        logic [1:0]            exc;
    } fq_entry_t;

    localparam int          EW      = $bits(fq_entry_t);
    localparam int          CW      = $clog2(QDEPTH) + 1;
    localparam logic [31:0] PC_STEP = 32'(4 * ISSUE_W);

    fq_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        live_q, live_d;

    logic          redir;
    logic [31:0]   redir_pc;
    logic          room;
    logic          enq, push, pop, byp;
    fq_entry_t     enq_entry, fifo_head, id_entry;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    assign redir    = exc_valid || redirect_valid;
    assign redir_pc = exc_valid ? exc_pc : redirect_pc;
    // In RUN nothing is outstanding, so any free slot can take the next group.
    assign room     = fifo_count < CW'(QDEPTH);

    // FSM next-state, request and enqueue decisions; redirect overrides all.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        live_d    = 1'b1;
        imem_req  = 1'b0;
        enq       = 1'b0;
        enq_entry = '0;
        case (state_q)
            ST_RUN: begin
                if (room && live_q) begin
                    if (pc_q[1:0] == 2'b00) begin
                        imem_req = !redir;
                        if (!redir && imem_ready) begin
                            state_d  = ST_WAIT;
                            pc_d     = pc_q + PC_STEP;
                            req_pc_d = pc_q;
                        end
                    end else begin
                        enq           = 1'b1;
                        enq_entry.pc  = pc_q;
                        enq_entry.exc = EXC_ADEL;
                        state_d       = ST_HALT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    enq            = 1'b1;
                    enq_entry.inst = imem_rdata;
                    enq_entry.pc   = req_pc_q;
                    enq_entry.exc  = EXC_NONE;
                    state_d        = ST_RUN;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) state_d = ST_RUN;
            end
            default: ;
        endcase
        if (redir) begin
            pc_d    = redir_pc;
            enq     = 1'b0;
            // A request still in flight must have its response swallowed.
            state_d = ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid)
                      ? ST_DROP : ST_RUN;
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            live_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            live_q   <= live_d;
        end
    end

`ifdef FETCH_BYPASS_EN
    assign byp = (state_q == ST_WAIT) && imem_rvalid && !redir && fifo_empty;
`else
    assign byp = 1'b0;
`endif

    assign pop  = !fifo_empty && id_ready && !redir;
    assign push = enq && !(byp && id_ready) && (!fifo_full || pop);

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .wdata (enq_entry),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign id_entry  = byp ? enq_entry : fifo_head;
    assign id_valid  = !fifo_empty || byp;
    assign id_inst   = id_entry.inst;
    assign id_pc     = id_entry.pc;
    assign id_exc    = id_entry.exc;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

endmodule
